// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that drains an 8-bit synchronous FIFO through its rd_en/empty handshake.
// All outputs are registered; each is computed from the next-state values so it lines up with the state it belongs to.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_rd_en_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       tx_done_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end_s;
    logic             fetch_ok_s;

    // Next-state logic for the frame sequencer, bit timer, bit index and shift register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        bit_end_s  = (cnt_q == CNT_LAST);
        fetch_ok_s = enable_i && !fifo_empty_i;
        case (state_q)
            S_IDLE: begin
                if (fetch_ok_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo_data_i;
                cnt_d   = '0;
                idx_d   = 3'd0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    // Back-to-back frames skip IDLE entirely.
                    if (fetch_ok_s) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
                shift_d = 8'h00;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs match the state they accompany.
    always_comb begin
        rd_en_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign tx_done_o    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, every popped byte becomes an
// expected frame, and a monitor compares tx/tx_done/busy cycle by cycle against the 8N1 frame arithmetic.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (fifo_data),
        .fifo_rd_en_o(fifo_rd_en),
        .tx_o        (tx),
        .busy_o      (busy),
        .tx_done_o   (tx_done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rd_cnt = 0;
    int         done_cnt = 0;
    logic       rst_seen = 1'b1;
    logic [7:0] fifo_q[$];
    logic [7:0] rd_byte = 8'h00;
    int         rd_cyc[$];
    int         exp_start[$];
    logic [7:0] exp_byte[$];
    logic       act = 1'b0;
    int         act_start = 0;
    logic [7:0] act_byte = 8'h00;

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, actual, expected);
        end
    endtask

    // FIFO read port: data appears the cycle after rd_en is sampled, junk otherwise.
    always @(posedge clk) begin
        rst_seen <= reset;
        if (fifo_rd_en) fifo_data <= rd_byte;
        else            fifo_data <= 8'($urandom);
    end

    // Monitor: pops the FIFO model on rd_en and checks every line cycle against the expected frame.
    always @(negedge clk) begin
        int         off;
        logic [9:0] fr;
        cyc++;
        if (rst_seen) begin
            chk("reset_tx", 32'(tx), 32'd1);
            chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_tx_done", 32'(tx_done), 32'd0);
            act = 1'b0;
            exp_start.delete();
            exp_byte.delete();
        end else begin
            if (fifo_rd_en) begin
                chk("rd_en_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                chk("rd_en_single", 32'(!act && exp_start.size() == 0), 32'd1);
                if (fifo_q.size() != 0) begin
                    rd_byte = fifo_q.pop_front();
                    exp_start.push_back(cyc + 2);
                    exp_byte.push_back(rd_byte);
                    rd_cyc.push_back(cyc);
                    rd_cnt++;
                    fifo_empty = (fifo_q.size() == 0);
                end
            end
            if (!act && exp_start.size() != 0 && exp_start[0] == cyc) begin
                act       = 1'b1;
                act_start = exp_start.pop_front();
                act_byte  = exp_byte.pop_front();
            end
            if (act) begin
                off = cyc - act_start;
                fr  = {1'b1, act_byte, 1'b0};
                chk("frame_tx", 32'(tx), 32'(fr[off / CPB]));
                chk("frame_tx_done", 32'(tx_done), 32'(off == FRAME - 1));
                chk("frame_busy", 32'(busy), 32'd1);
                if (off == FRAME - 1) begin
                    act = 1'b0;
                    done_cnt++;
                end
            end else begin
                chk("idle_tx", 32'(tx), 32'd1);
                chk("idle_tx_done", 32'(tx_done), 32'd0);
                chk("idle_busy", 32'(busy), 32'(exp_start.size() != 0));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        chk("done_count", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        int rd0, dn0, decide, b0;
        // Reset held with a non-empty FIFO and enable high.
        push(8'h5A);
        step(2);
        reset = 1'b0;
        enable = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        step(3);
        chk("post_reset_rd_cnt", 32'(rd_cnt), 32'd0);

        // Single byte A1 with start latency.
        rd0 = rd_cnt; dn0 = done_cnt; b0 = rd_cyc.size();
        push(8'hA1);
        enable = 1'b1;
        decide = cyc + 1;
        wait_done(dn0 + 1, 200);
        step(5);
        chk("single_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
        chk("single_latency", 32'(rd_cyc[b0]), 32'(decide + 1));
        chk("single_busy_low", 32'(busy), 32'd0);

        // Back-to-back A1, B2, C3.
        enable = 1'b0;
        rd0 = rd_cnt; dn0 = done_cnt; b0 = rd_cyc.size();
        push(8'hA1); push(8'hB2); push(8'hC3);
        enable = 1'b1;
        wait_done(dn0 + 3, 600);
        step(4);
        chk("b2b_rd_cnt", 32'(rd_cnt - rd0), 32'd3);
        for (int i = 0; i < 2; i++) begin
            if (rd_cyc.size() > b0 + i + 1)
                chk("b2b_spacing", 32'(rd_cyc[b0 + i + 1] - rd_cyc[b0 + i]), 32'(FRAME + 2));
        end
        chk("b2b_fifo_empty", 32'(fifo_empty), 32'd1);

        // Enable gating.
        enable = 1'b0;
        rd0 = rd_cnt; dn0 = done_cnt;
        push(8'($urandom)); push(8'($urandom));
        step(50);
        chk("gate_no_rd", 32'(rd_cnt - rd0), 32'd0);
        enable = 1'b1;
        for (int k = 0; k < 10 && rd_cnt == rd0; k++) step(1);
        step(20);
        enable = 1'b0;
        wait_done(dn0 + 1, 200);
        step(50);
        chk("gate_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
        chk("gate_fifo_left", 32'(fifo_q.size()), 32'd1);
        fifo_q.delete();
        fifo_empty = 1'b1;

        // Reset during data bit 3 of B2, then C3 goes out intact.
        rd0 = rd_cnt; dn0 = done_cnt;
        push(8'hB2); push(8'hC3);
        enable = 1'b1;
        for (int k = 0; k < 10 && rd_cnt == rd0; k++) step(1);
        step(17);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wait_done(dn0 + 1, 200);
        step(4);
        chk("rstmid_rd_cnt", 32'(rd_cnt - rd0), 32'd2);
        chk("rstmid_fifo_empty", 32'(fifo_empty), 32'd1);

        // Empty FIFO with enable high.
        rd0 = rd_cnt;
        step(100);
        chk("empty_no_rd", 32'(rd_cnt - rd0), 32'd0);

        // Random bytes back to back.
        enable = 1'b0;
        rd0 = rd_cnt; dn0 = done_cnt;
        for (int i = 0; i < 5; i++) push(8'($urandom));
        enable = 1'b1;
        wait_done(dn0 + 5, 1000);
        step(4);
        chk("rand_rd_cnt", 32'(rd_cnt - rd0), 32'd5);
        chk("rand_fifo_empty", 32'(fifo_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
